// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, addi, j).
// Define MIPS_CTRL_BNE_EN to add bne (opcode 0x05) through a dedicated BNE state.
module mips_multicycle_control (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic [3:0] ALUControl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_BNE    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_NOR = 6'h27;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   state_t     state_q, state_d;
   logic       funct_legal;
   logic [3:0] funct_alu;

   // R-type function decode, shared by the DECODE legality check and EXEC.
   always_comb begin
      funct_legal = 1'b1;
      funct_alu   = ALU_ADD;
      case (Funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         FN_NOR:  funct_alu = ALU_NOR;
         default: funct_legal = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; illegal decodes fall straight back to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               OP_RTYPE: state_d = funct_legal ? S_EXEC : S_FETCH;
               OP_LW,
               OP_SW:    state_d = S_MEMADR;
               OP_BEQ:   state_d = S_BRANCH;
               OP_ADDI:  state_d = S_ADDIEX;
               OP_J:     state_d = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
               OP_BNE:   state_d = S_BNE;
`endif
               default:  state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Moore outputs; Zero and Funct only enter through BRANCH/BNE and EXEC/DECODE.
   always_comb begin
      ALUControl = ALU_ADD;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSource   = 2'b00;
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      Illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = 1'b1;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (Opcode)
               OP_RTYPE: Illegal = ~funct_legal;
               OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: Illegal = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
               OP_BNE:   Illegal = 1'b0;
`endif
               default:  Illegal = 1'b1;
            endcase
         end
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA    = 1'b1;
            ALUControl = funct_alu;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSource   = 2'b01;
            PCWrite    = Zero;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
         end
`ifdef MIPS_CTRL_BNE_EN
         S_BNE: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSource   = 2'b01;
            PCWrite    = ~Zero;
         end
`endif
         default: ;
      endcase
   end

   assign State = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction micro-step model, random
// instruction mix, reset abort cases. Honours MIPS_CTRL_BNE_EN when defined.
module tb_mips_multicycle_control;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic [5:0] Opcode = 6'h00;
   logic [5:0] Funct = 6'h20;
   logic       Zero = 1'b0;
   logic [3:0] ALUControl;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSource;
   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
   logic       RegWrite, RegDst, MemtoReg, Illegal;
   logic [3:0] State;

   int tests_run = 0;
   int tests_failed = 0;

   logic [21:0] exp_q[$];

   mips_multicycle_control dut (
      .Clock(Clock), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .Illegal(Illegal), .State(State)
   );

   always #5 Clock = ~Clock;

   // Observed control word, fields in port order after State.
   logic [21:0] obs;
   assign obs = {State, ALUControl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD,
                 MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Illegal};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (state %0d, t=%0t)", tag, got, exp, State, $time);
      end
   endtask

   function automatic logic [21:0] cw(int st, int alu, bit sa, int sb, int ps, bit pw,
                                      bit iord, bit mr, bit mw, bit ir, bit rw, bit rd,
                                      bit m2r, bit ill);
      cw = {st[3:0], alu[3:0], sa, sb[1:0], ps[1:0], pw, iord, mr, mw, ir, rw, rd, m2r, ill};
   endfunction

   // R-type ALU code per the ALU table; -1 marks an unsupported funct.
   function automatic int alu_of(logic [5:0] fn);
      case (fn)
         6'h20: return 2;
         6'h22: return 6;
         6'h24: return 0;
         6'h25: return 1;
         6'h2A: return 7;
         6'h27: return 12;
         default: return -1;
      endcase
   endfunction

   function automatic bit bne_enabled();
`ifdef MIPS_CTRL_BNE_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Expected per-cycle control words for one whole instruction.
   task automatic build_expected(input logic [5:0] op, input logic [5:0] fn, input bit z);
      bit legal;
      exp_q.delete();
      exp_q.push_back(cw(0, 2, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
      legal = (op == 6'h00 && alu_of(fn) >= 0) || op == 6'h23 || op == 6'h2B ||
              op == 6'h04 || op == 6'h08 || op == 6'h02 || (op == 6'h05 && bne_enabled());
      exp_q.push_back(cw(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, !legal));
      if (legal) begin
         case (op)
            6'h00: begin
               exp_q.push_back(cw(6, alu_of(fn), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               exp_q.push_back(cw(7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
            end
            6'h23: begin
               exp_q.push_back(cw(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               exp_q.push_back(cw(3, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
               exp_q.push_back(cw(4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
            end
            6'h2B: begin
               exp_q.push_back(cw(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               exp_q.push_back(cw(5, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
            end
            6'h04: exp_q.push_back(cw(8, 6, 1, 0, 1, z, 0, 0, 0, 0, 0, 0, 0, 0));
            6'h05: exp_q.push_back(cw(12, 6, 1, 0, 1, !z, 0, 0, 0, 0, 0, 0, 0, 0));
            6'h08: begin
               exp_q.push_back(cw(9, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               exp_q.push_back(cw(10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            default: exp_q.push_back(cw(11, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
         endcase
      end
   endtask

   // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
   // Inputs carry the real instruction only where the model says they matter;
   // elsewhere they are scrambled to show they are ignored.
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input bit z, input int abort_at);
      logic [21:0] e;
      int st;
      build_expected(op, fn, z);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         st = int'(e[21:18]);
         if (st == 1 || st == 2 || st == 6) begin
            Opcode = op;
            Funct  = fn;
         end else begin
            Opcode = 6'($urandom_range(0, 63));
            Funct  = 6'($urandom_range(0, 63));
         end
         Zero = (st == 8 || st == 12) ? z : 1'($urandom_range(0, 1));
         #1;
         check(tag, 32'(obs), 32'(e));
         if (st == abort_at) begin
            #2 Reset_n = 1'b0;
            #1 check({tag, "_abort"}, 32'(obs), 32'(cw(0, 2, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0)));
            @(negedge Clock);
            Reset_n = 1'b1;
            exp_q.delete();
         end else begin
            @(negedge Clock);
         end
      end
   endtask

   initial begin
      logic [5:0] op, fn;
      logic [5:0] legal_fn[6];
      logic [5:0] legal_op[6];
      legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
      legal_op = '{6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h05};

      repeat (3) begin
         @(negedge Clock);
         #1 check("reset", 32'(obs), 32'(cw(0, 2, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0)));
      end
      @(negedge Clock);
      Reset_n = 1'b1;
      Opcode  = 6'h00;
      Funct   = 6'h20;
      @(posedge Clock);
      #1 check("rst_release", 32'(State), 32'd1);
      @(negedge Clock);
      Reset_n = 1'b0;
      #1 check("rst_in_decode", 32'(obs), 32'(cw(0, 2, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0)));
      @(negedge Clock);
      Reset_n = 1'b1;

      run_instr("sub", 6'h00, 6'h22, 1'b0, -1);
      run_instr("lw", 6'h23, 6'h00, 1'b0, -1);
      run_instr("beq_taken", 6'h04, 6'h00, 1'b1, -1);
      run_instr("beq_not", 6'h04, 6'h00, 1'b0, -1);
      run_instr("ill_op", 6'h3F, 6'h20, 1'b0, -1);
      run_instr("ill_fn", 6'h00, 6'h08, 1'b0, -1);
      run_instr("sw_abort", 6'h2B, 6'h00, 1'b0, 5);
      run_instr("sw", 6'h2B, 6'h11, 1'b1, -1);
      run_instr("addi", 6'h08, 6'h3F, 1'b0, -1);
      run_instr("j", 6'h02, 6'h00, 1'b1, -1);
      run_instr("bne_z0", 6'h05, 6'h00, 1'b0, -1);
      run_instr("bne_z1", 6'h05, 6'h00, 1'b1, -1);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: begin op = 6'h00; fn = legal_fn[$urandom_range(0, 5)]; end
            1: begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
            2: begin op = legal_op[$urandom_range(0, 5)]; fn = 6'($urandom_range(0, 63)); end
            default: begin op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
         endcase
         run_instr("rand", op, fn, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 11)) : -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
